// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU macro-op sequencer.
// - Datapath/opcode/count widths.
// - op_mne: opcode mnemonics understood by the 8-bit combinational ALU.
// - mac_cmd_t: macro-ops requested by the control unit.
// - seq_state_t: sequencer FSM states.
package alu_op_sequencer_pkg;

  localparam int W   = 8;  // datapath width; ALU shifts are hard-wired to 8 bits
  localparam int Ops = 3;  // ALU opcode width
  localparam int CW  = 3;  // shift-count width, counts 0..7

  typedef enum logic [Ops-1:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    ANDL = 3'd2,
    ORL  = 3'd3,
    XORL = 3'd4,
    NOTA = 3'd5,
    LSH  = 3'd6,  // Out = {InputA[6:0], SC_in}
    RSH  = 3'd7   // Out = {SC_in, InputA[7:1]}
  } op_mne;

  typedef enum logic [1:0] {
    SHL_N = 2'd0,
    SHR_N = 2'd1,
    ROL_N = 2'd2,
    MUL8  = 2'd3
  } mac_cmd_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    MUL_ADD = 3'd2,
    MUL_SHL = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Control-unit side handshake of the sequencer.
// master: control unit (drives start/cmd/operands, observes busy/done/result).
// slave : sequencer.
interface alu_op_sequencer_if;
  import alu_op_sequencer_pkg::*;

  logic          start;
  mac_cmd_t      cmd;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          res_zero;

  modport master (
    output start, cmd, a_in, b_in, count,
    input  busy, done, result, res_zero
  );

  modport slave (
    input  start, cmd, a_in, b_in, count,
    output busy, done, result, res_zero
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle initiator driving an 8-bit combinational ALU, one primitive op
// per cycle, to execute shift-by-N, rotate-by-N and 8x8 multiply (low byte).
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset
//   ctl          : control-unit handshake (start/cmd/a_in/b_in/count in,
//                  busy/done/result/res_zero out)
//   alu_op/alu_a/alu_b/alu_sc : combinational drive of the ALU inputs
//   alu_out      : ALU result
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  alu_op_sequencer_if.slave   ctl,
  output op_mne               alu_op,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic                alu_sc,
  input  logic [W-1:0]        alu_out
);

  seq_state_t    state_reg, state_next;
  mac_cmd_t      cmd_reg, cmd_next;
  logic [W-1:0]  acc_reg, acc_next;
  logic [W-1:0]  mcand_reg, mcand_next;
  logic [W-1:0]  mplier_reg, mplier_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [W-1:0]  result_reg, result_next;
  logic          res_zero_reg, res_zero_next;
  logic [2:0]    idx_inc;

  assign idx_inc = idx_reg + 3'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      cmd_reg      <= SHL_N;
      acc_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      result_reg   <= '0;
      res_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      acc_reg      <= acc_next;
      mcand_reg    <= mcand_next;
      mplier_reg   <= mplier_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      result_reg   <= result_next;
      res_zero_reg <= res_zero_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    acc_next      = acc_reg;
    mcand_next    = mcand_reg;
    mplier_next   = mplier_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    result_next   = result_reg;
    res_zero_next = res_zero_reg;
    alu_op        = ADD;
    alu_a         = '0;
    alu_b         = '0;
    alu_sc        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ctl.start) begin
          cmd_next    = ctl.cmd;
          cnt_next    = ctl.count;
          mcand_next  = ctl.a_in;
          mplier_next = ctl.b_in;
          idx_next    = '0;
          if (ctl.cmd == MUL8) begin
            acc_next   = '0;
            state_next = ctl.b_in[0] ? MUL_ADD : MUL_SHL;
          end else begin
            acc_next   = ctl.a_in;
            state_next = (ctl.count != '0) ? SHIFT : DONE;
          end
        end
      end

      SHIFT: begin
        alu_a = acc_reg;
        case (cmd_reg)
          SHR_N: alu_op = RSH;
          ROL_N: begin
            alu_op = LSH;
            alu_sc = acc_reg[W-1];  // MSB wraps into LSB
          end
          default: alu_op = LSH;
        endcase
        acc_next = alu_out;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == 1) state_next = DONE;
      end

      MUL_ADD: begin
        alu_op     = ADD;
        alu_a      = acc_reg;
        alu_b      = mcand_reg;
        acc_next   = alu_out;
        state_next = MUL_SHL;
      end

      MUL_SHL: begin
        alu_op     = LSH;
        alu_a      = mcand_reg;
        mcand_next = alu_out;
        idx_next   = idx_inc;
        if (idx_reg == 3'd7)
          state_next = DONE;
        else
          state_next = mplier_reg[idx_inc] ? MUL_ADD : MUL_SHL;
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase

    // Capture on the edge entering DONE so result is valid alongside done.
    if (state_next == DONE) begin
      result_next   = acc_next;
      res_zero_next = (acc_next == '0);
    end
  end

  assign ctl.busy     = (state_reg == SHIFT) || (state_reg == MUL_ADD) ||
                        (state_reg == MUL_SHL);
  assign ctl.done     = (state_reg == DONE);
  assign ctl.result   = result_reg;
  assign ctl.res_zero = res_zero_reg;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle initiator that drives the combinational 8-bit ALU one primitive op per cycle to execute macro-ops the ALU cannot do in one pass: shift-by-N, rotate-by-N and 8x8 multiply (low byte).
- Sits between the control unit and the ALU. It owns OP/InputA/InputB/SC_in for the duration of a macro-op and consumes ALU Out.
- The control unit interfaces through a start/busy/done handshake.

Parameters:
- W, 8, datapath width; must be 8, because the ALU shift ops are hard-wired to 8 bits.
- Ops, 3, ALU opcode width.
- CW, 3, shift-count width; counts 0..7.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- cmd  input  2  macro-op, from mac_cmd_t: SHL_N=0, SHR_N=1, ROL_N=2, MUL8=3.
- a_in  input  W  operand A (value shifted, or multiplicand).
- b_in  input  W  operand B (multiplier; ignored by shifts).
- count  input  CW  shift amount; ignored by MUL8.
- alu_op  output  Ops  opcode to ALU OP, from op_mne in definitions.
- alu_a  output  W  to ALU InputA.
- alu_b  output  W  to ALU InputB.
- alu_sc  output  1  to ALU SC_in.
- alu_out  input  W  from ALU Out.
- busy  output  1  high while a macro-op is executing.
- done  output  1  one-cycle pulse when result is valid.
- result  output  W  final value; held until the next accepted start.
- res_zero  output  1  result == 0; registered alongside result.

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, result=0, res_zero=0.
  - Internal acc/mcand/mplier/cnt/bit index = 0.
  - Reset asserted mid-operation aborts it; no done pulse is produced.
- ALU drive:
  - In IDLE and DONE, drive alu_op=ADD, alu_a=0, alu_b=0, alu_sc=0.
  - ALU drive outputs are combinational from state and registers.
- States: IDLE, SHIFT, MUL_ADD, MUL_SHL, DONE.
- IDLE:
  - start=1 latches cmd, count, acc<=a_in, mcand<=a_in, mplier<=b_in, idx<=0.
  - For MUL8, acc<=0.
  - Next state:
    - SHL_N/SHR_N/ROL_N: SHIFT if count!=0, else DONE.
    - MUL8: MUL_ADD if b_in[0], else MUL_SHL.
- SHIFT, one primitive per cycle, acc<=alu_out, cnt decrements:
  - SHL_N: alu_op=LSH, alu_sc=0.
  - SHR_N: alu_op=RSH.
  - ROL_N: alu_op=LSH, alu_sc=acc[7].
  - Exit to DONE after the cycle in which cnt reaches 0, i.e. exactly count SHIFT cycles.
- MUL_ADD:
  - alu_op=ADD, alu_a=acc, alu_b=mcand; acc<=alu_out.
  - Next state MUL_SHL.
- MUL_SHL:
  - alu_op=LSH, alu_a=mcand, alu_sc=0; mcand<=alu_out; idx<=idx+1.
  - If idx==7, go to DONE.
  - Otherwise go to MUL_ADD if mplier[idx+1], else MUL_SHL.
  - The multiplier bit test is local, not an ALU op.
- DONE:
  - done=1 for exactly one cycle; result<=acc and res_zero<=(acc==0) on entry edge, so both are valid while done=1.
  - Next state IDLE.
- busy: =1 in SHIFT, MUL_ADD, MUL_SHL; 0 in IDLE and DONE.
- start handling: start while busy or in DONE is ignored; no queuing.
- Latency from the start edge to done cycle:
  - Shifts: count+1 cycles.
  - MUL8: 8+popcount(b_in)+1 cycles.
- Arithmetic: all results mod 256; ADD carry-out discarded.

Decomposition:
- Package definitions:
  - Add typedef enum mac_cmd_t {SHL_N, SHR_N, ROL_N, MUL8} (2 bits).
  - Add typedef enum seq_state_t.
  - Reuse the existing op_mne for alu_op.
- No sub-module inside the sequencer. The testbench instantiates it with the existing ALU as a top-level pair.

Test Plan:
- Reset, then idle: Reset=1 for 2 cycles → busy=0, done=0, result=0, alu_op=ADD, alu_a=alu_b=0.
- SHL_N: a_in=8'h81, count=3 → 3 busy cycles, done at start+4, result=8'h08, res_zero=0.
- ROL_N and SHR_N:
  - ROL_N a_in=8'h81, count=1 → result=8'h03.
  - SHR_N a_in=8'h80, count=7 → result=8'h01.
  - Any shift with count=0 → done at start+1, result=a_in.
- MUL8:
  - a_in=3, b_in=5 → 10 busy cycles, done at start+11, result=15.
  - a_in=16, b_in=16 → result=0, res_zero=1.
  - a_in=255, b_in=255 → result=8'h01, done at start+17.
- Protocol:
  - Pulse start again during busy with a different cmd → ignored; first result unchanged.
  - Back-to-back: start held high → next op accepted in the IDLE cycle after DONE.
- Reset mid-op: assert Reset during cycle 4 of a MUL8 → no done pulse, result=0; a fresh start then completes normally.
